// File: rtl/uart_tx_multibyte.sv
// uart_tx_multibyte
//   Serialises a NUM_BYTES-character word as back-to-back UART characters on
//   one TX line. Each character is sent as follows:
//     - one start bit (0);
//     - BITS_DADOS data bits, LSB first;
//     - an optional parity bit (odd or even);
//     - BITS_PARADA stop bits (1).
//   Character 0 (the low slice of the word) goes out first.
// Ports
//   clock                  system clock, rising edge
//   reset_n                async active-low reset; aborts any frame in flight
//   haDadosParaTransmitir  valid for palavraASerTransmitida
//   palavraASerTransmitida word to send (NUM_BYTES*BITS_DADOS bits)
//   prontoParaReceber      ready; high exactly while idle (ESPERA)
//   indicaTransmissao      busy, from accept until the last stop bit ends
//   bitSerialAtual         registered TX line, idles high
//   bitsEstaoEnviados      one-cycle pulse when a word has been fully sent
module uart_tx_multibyte #(
  parameter int CLOCKS_POR_BIT = 5209,
  parameter int BITS_DADOS     = 8,
  parameter int NUM_BYTES      = 2,
  parameter int PARIDADE       = 0,
  parameter int BITS_PARADA    = 1
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              haDadosParaTransmitir,
  input  logic [NUM_BYTES*BITS_DADOS-1:0]   palavraASerTransmitida,
  output logic                              prontoParaReceber,
  output logic                              indicaTransmissao,
  output logic                              bitSerialAtual,
  output logic                              bitsEstaoEnviados
);

  localparam int CW = $clog2(CLOCKS_POR_BIT);
  // BITS_DADOS >= 5, so this index also covers the (at most 2) stop bits.
  localparam int BW = $clog2(BITS_DADOS);
  localparam int KW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic [2:0] {
    S_ESPERA, S_INICIO, S_DADOS, S_PARIDADE, S_PARADA
  } state_e;

  state_e                                state_q, state_d;
  logic [CW-1:0]                         cnt_q, cnt_d;
  logic [BW-1:0]                         bit_q, bit_d;
  logic [KW-1:0]                         chr_q, chr_d;
  logic [NUM_BYTES-1:0][BITS_DADOS-1:0]  word_q, word_d;
  logic                                  serial_q, serial_d;
  logic                                  busy_q, busy_d;
  logic                                  done_q, done_d;

  logic                  accept, tick, last_data, last_stop, last_chr;
  logic [BITS_DADOS-1:0] char_bits;

  assign accept    = (state_q == S_ESPERA) && haDadosParaTransmitir;
  assign tick      = (cnt_q == CW'(CLOCKS_POR_BIT - 1));
  assign last_data = (bit_q == BW'(BITS_DADOS - 1));
  assign last_stop = (bit_q == BW'(BITS_PARADA - 1));
  assign last_chr  = (chr_q == KW'(NUM_BYTES - 1));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_ESPERA;
      cnt_q    <= '0;
      bit_q    <= '0;
      chr_q    <= '0;
      word_q   <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      chr_q    <= chr_d;
      word_q   <= word_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic. bit_q doubles as the stop-bit counter in PARADA.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    chr_d   = chr_q;
    word_d  = word_q;
    if (state_q == S_ESPERA) begin
      if (accept) begin
        state_d = S_INICIO;
        word_d  = palavraASerTransmitida;
        cnt_d   = '0;
        bit_d   = '0;
        chr_d   = '0;
      end
    end else begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      if (tick) begin
        case (state_q)
          S_INICIO: begin
            state_d = S_DADOS;
            bit_d   = '0;
          end
          S_DADOS: begin
            if (last_data) begin
              bit_d   = '0;
              state_d = (PARIDADE != 0) ? S_PARIDADE : S_PARADA;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
          S_PARIDADE: begin
            state_d = S_PARADA;
            bit_d   = '0;
          end
          S_PARADA: begin
            if (last_stop) begin
              bit_d = '0;
              if (last_chr) begin
                state_d = S_ESPERA;
                chr_d   = '0;
              end else begin
                state_d = S_INICIO;
                chr_d   = chr_q + KW'(1);
              end
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
          default: state_d = S_ESPERA;
        endcase
      end
    end
  end

  // Output logic: the line register is loaded with the level of the bit being
  // entered, so the start bit appears on the accept edge itself. The data
  // path reads word_q, which is only needed from INICIO onward.
  always_comb begin
    char_bits = word_q[chr_d];
    serial_d  = 1'b1;
    case (state_d)
      S_INICIO:   serial_d = 1'b0;
      S_DADOS:    serial_d = char_bits[bit_d];
      S_PARIDADE: serial_d = (PARIDADE == 1) ? ~^char_bits : ^char_bits;
      default:    serial_d = 1'b1;
    endcase
    busy_d = (state_d != S_ESPERA);
    done_d = (state_q == S_PARADA) && tick && last_stop && last_chr;
  end

  assign prontoParaReceber = (state_q == S_ESPERA);
  assign indicaTransmissao = busy_q;
  assign bitSerialAtual    = serial_q;
  assign bitsEstaoEnviados = done_q;

endmodule
